// File: rtl/fft_parallel_unloader.sv
// Parallel-to-serial output stage of the DIF FFT: captures a full frame in one
// cycle and streams it out one sample per accepted beat, optionally in natural order.
module fft_parallel_unloader #(
  parameter int DATA_WIDTH = 24,
  parameter int POW        = 3,
  parameter bit BIT_REV    = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [(2**POW)*DATA_WIDTH-1:0]    sink_r,
  input  logic [(2**POW)*DATA_WIDTH-1:0]    sink_i,
  output logic                              source_valid,
  input  logic                              source_ready,
  output logic signed [DATA_WIDTH-1:0]      source_r,
  output logic signed [DATA_WIDTH-1:0]      source_i,
  output logic [POW-1:0]                    source_idx,
  output logic                              source_sop,
  output logic                              source_eop
);

  localparam int N = 2**POW;
  localparam logic [POW-1:0] LAST = POW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                       state_q;
  logic [POW-1:0]               cnt_q;
  logic signed [DATA_WIDTH-1:0] buf_r_q [N];
  logic signed [DATA_WIDTH-1:0] buf_i_q [N];
  logic [POW-1:0]               addr;
  logic                         last;
  logic                         load_fire;
  logic                         out_fire;

  assign source_valid = (state_q == STREAM);
  assign last         = (cnt_q == LAST);
  // Ready may rise combinationally on the eop beat so the next frame lands with no bubble.
  assign load_ready   = (state_q == IDLE) | (source_valid & last & source_ready);
  assign load_fire    = load_valid & load_ready;
  assign out_fire     = source_valid & source_ready;

  generate
    if (BIT_REV) begin : g_rev
      for (genvar b = 0; b < POW; b++) begin : g_bit
        assign addr[b] = cnt_q[POW-1-b];
      end
    end else begin : g_lin
      assign addr = cnt_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_fire) begin
            state_q <= STREAM;
            cnt_q   <= '0;
          end
        end
        STREAM: begin
          if (out_fire) begin
            if (last) begin
              cnt_q <= '0;
              if (!load_fire) state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        buf_r_q[j] <= '0;
        buf_i_q[j] <= '0;
      end
    end else if (load_fire) begin
      for (int j = 0; j < N; j++) begin
        buf_r_q[j] <= sink_r[j*DATA_WIDTH +: DATA_WIDTH];
        buf_i_q[j] <= sink_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign source_r   = source_valid ? buf_r_q[addr] : '0;
  assign source_i   = source_valid ? buf_i_q[addr] : '0;
  assign source_idx = source_valid ? cnt_q : '0;
  assign source_sop = source_valid & (cnt_q == '0);
  assign source_eop = source_valid & last;

endmodule

// File: tb/tb_fft_parallel_unloader.sv
// Self-checking bench: drives a buffer-order and a natural-order instance in lockstep
// and compares both against a frame/position reference model every cycle.
module tb_fft_parallel_unloader;

  localparam int DW  = 24;
  localparam int POW = 3;
  localparam int N   = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic loadValid;
  logic sourceReady;
  logic [N*DW-1:0] sinkR, sinkI;

  logic ldRdy0, vld0, sop0, eop0, ldRdy1, vld1, sop1, eop1;
  logic signed [DW-1:0] r0, i0, r1, i1;
  logic [POW-1:0] idx0, idx1;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  logic signed [DW-1:0] pendR [N];
  logic signed [DW-1:0] pendI [N];
  logic signed [DW-1:0] modR [N];
  logic signed [DW-1:0] modI [N];
  bit mActive;
  int mPos;
  bit lastLoad;
  bit lvHold;

  always #5 clk = ~clk;

  fft_parallel_unloader #(.DATA_WIDTH(DW), .POW(POW), .BIT_REV(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(loadValid), .load_ready(ldRdy0),
    .sink_r(sinkR), .sink_i(sinkI), .source_valid(vld0), .source_ready(sourceReady),
    .source_r(r0), .source_i(i0), .source_idx(idx0), .source_sop(sop0), .source_eop(eop0)
  );

  fft_parallel_unloader #(.DATA_WIDTH(DW), .POW(POW), .BIT_REV(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(loadValid), .load_ready(ldRdy1),
    .sink_r(sinkR), .sink_i(sinkI), .source_valid(vld1), .source_ready(sourceReady),
    .source_r(r1), .source_i(i1), .source_idx(idx1), .source_sop(sop1), .source_eop(eop1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int bitRev(input int v);
    int rev = 0;
    for (int k = 0; k < POW; k++) begin
      rev = rev * 2 + (v % 2);
      v = v / 2;
    end
    return rev;
  endfunction

  // Expected outputs follow directly from the model's current frame and position.
  task automatic checkAll();
    bit expRdy;
    logic signed [DW-1:0] er0, ei0, er1, ei1;
    expRdy = !mActive || (mPos == N-1 && sourceReady);
    er0 = mActive ? modR[mPos] : '0;
    ei0 = mActive ? modI[mPos] : '0;
    er1 = mActive ? modR[bitRev(mPos)] : '0;
    ei1 = mActive ? modI[bitRev(mPos)] : '0;
    checkOutput("loadReady0", {31'b0, ldRdy0}, {31'b0, expRdy});
    checkOutput("loadReady1", {31'b0, ldRdy1}, {31'b0, expRdy});
    checkOutput("valid0", {31'b0, vld0}, {31'b0, mActive});
    checkOutput("valid1", {31'b0, vld1}, {31'b0, mActive});
    checkOutput("real0", {8'b0, r0}, {8'b0, er0});
    checkOutput("imag0", {8'b0, i0}, {8'b0, ei0});
    checkOutput("real1", {8'b0, r1}, {8'b0, er1});
    checkOutput("imag1", {8'b0, i1}, {8'b0, ei1});
    checkOutput("idx0", {29'b0, idx0}, mActive ? 32'(mPos) : 32'd0);
    checkOutput("idx1", {29'b0, idx1}, mActive ? 32'(mPos) : 32'd0);
    checkOutput("sop", {30'b0, sop0, sop1}, (mActive && mPos == 0) ? 32'd3 : 32'd0);
    checkOutput("eop", {30'b0, eop0, eop1}, (mActive && mPos == N-1) ? 32'd3 : 32'd0);
  endtask

  task automatic applyStimulus(input bit lv, input bit rdy);
    bit expRdy, ldFire, outFire;
    @(negedge clk);
    loadValid   = lv;
    sourceReady = rdy;
    for (int j = 0; j < N; j++) begin
      sinkR[j*DW +: DW] = pendR[j];
      sinkI[j*DW +: DW] = pendI[j];
    end
    #1;
    checkAll();
    expRdy  = !mActive || (mPos == N-1 && rdy);
    ldFire  = lv && expRdy;
    outFire = mActive && rdy;
    if (outFire) xfers++;
    if (outFire && mPos == N-1) begin
      mActive = 1'b0;
      mPos    = 0;
    end else if (outFire) begin
      mPos++;
    end
    if (ldFire) begin
      for (int j = 0; j < N; j++) begin
        modR[j] = pendR[j];
        modI[j] = pendI[j];
      end
      mActive = 1'b1;
      mPos    = 0;
    end
    lastLoad = ldFire;
  endtask

  task automatic randomFrame();
    for (int j = 0; j < N; j++) begin
      pendR[j] = DW'($urandom);
      pendI[j] = DW'($urandom);
    end
  endtask

  task automatic rampFrame(input int base);
    for (int j = 0; j < N; j++) begin
      pendR[j] = DW'(base + j);
      pendI[j] = DW'(-(base + j));
    end
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mActive = 1'b0;
    mPos    = 0;
    for (int j = 0; j < N; j++) begin
      modR[j] = '0;
      modI[j] = '0;
    end
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k;
    rst_n = 1'b0;
    loadValid = 1'b0;
    sourceReady = 1'b0;
    sinkR = '0;
    sinkI = '0;
    mActive = 1'b0;
    mPos = 0;
    lvHold = 1'b0;
    lastLoad = 1'b0;
    for (int j = 0; j < N; j++) begin
      modR[j] = '0;
      modI[j] = '0;
      pendR[j] = '0;
      pendI[j] = '0;
    end
    #12;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp frame, continuous ready: buffer order and bit-reversed order together.
    rampFrame(1);
    applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b1);

    // Stalls during a frame.
    randomFrame();
    applyStimulus(1'b1, 1'b1);
    xfers = 0;
    k = 0;
    while (mActive && k < 60) begin
      applyStimulus(1'b0, pattern[k % 4]);
      k++;
    end
    checkOutput("xferCount", 32'(xfers), 32'd8);
    repeat (2) applyStimulus(1'b0, 1'b1);

    // Second frame held from beat 3, accepted only on the eop beat.
    rampFrame(1);
    applyStimulus(1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1);
    rampFrame(101);
    k = 0;
    while (!lastLoad && k < 20) begin
      applyStimulus(1'b1, 1'b1);
      k++;
    end
    checkOutput("b2bLoadBeat", 32'(k), 32'd5);
    repeat (10) applyStimulus(1'b0, 1'b1);

    // Reset mid-frame, then a fresh frame.
    randomFrame();
    applyStimulus(1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1);
    resetPulse();
    randomFrame();
    applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b1);

    // Full-scale extremes.
    randomFrame();
    pendR[0] = 24'sh800000;
    pendI[0] = 24'sh7FFFFF;
    pendR[5] = 24'sh7FFFFF;
    pendI[5] = 24'sh800000;
    applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b1);

    // Random traffic with frames held until accepted.
    repeat (3000) begin
      if (!lvHold && $urandom_range(0, 2) == 0) begin
        randomFrame();
        lvHold = 1'b1;
      end
      applyStimulus(lvHold, $urandom_range(0, 3) != 0);
      if (lastLoad) lvHold = 1'b0;
    end
    repeat (40) applyStimulus(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_parallel_unloader.md
# fft_parallel_unloader

Parallel-to-serial output stage for the radix-2 DIF FFT pipeline. It captures one frame of 2^POW complex results in a single cycle and streams them out one sample per accepted beat. It optionally reorders the bit-reversed DIF output into natural frequency order, and marks frame boundaries with start-of-packet and end-of-packet flags. It sits after the butterfly/twiddle stages, at the opposite end of the datapath from the serial-to-parallel input collector.

## Interface
- DATA_WIDTH, 24: bit width of each real/imaginary component, in and out
- POW, 3: log2(N) where N = 2^POW points per frame; legal range 1..10
- BIT_REV, 1: 1 = output in natural order (read bit-reversed addresses); 0 = output in buffer order

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load_valid  in  1  parallel frame present on sink_r/sink_i
- load_ready  out  1  block can accept a frame this cycle
- sink_r  in  signed [DATA_WIDTH-1:0] x N  parallel real inputs, index 0..N-1
- sink_i  in  signed [DATA_WIDTH-1:0] x N  parallel imaginary inputs
- source_valid  out  1  source_r/source_i hold a valid sample
- source_ready  in  1  downstream accepts the sample this cycle
- source_r  out  signed [DATA_WIDTH-1:0]  serial real output
- source_i  out  signed [DATA_WIDTH-1:0]  serial imaginary output
- source_idx  out  POW  natural-order bin index of the current sample
- source_sop  out  1  first sample of frame
- source_eop  out  1  last sample of frame

## Operation
- Load transfer: load_valid & load_ready. Output transfer: source_valid & source_ready.
- Internal frame buffer: buf_r/buf_i, N entries. A load transfer writes all N entries in one cycle.
- FSM states:
  - IDLE: load_ready=1, source_valid=0. A load transfer captures the frame, sets cnt=0, and moves to STREAM.
  - STREAM: source_valid=1.
    - An output transfer with cnt<N-1 increments cnt.
    - An output transfer with cnt==N-1 moves to IDLE, unless a load occurs in the same cycle. In that case the block captures the new frame, clears cnt to 0, and stays in STREAM.
- load_ready = (state==IDLE) | (state==STREAM & cnt==N-1 & source_ready). This path from source_ready to load_ready is combinational and intentional; it enables back-to-back frames.
- Read address: addr = BIT_REV ? bit-reverse(cnt, POW bits) : cnt.
  - source_r/source_i = buf[addr] while source_valid; forced to 0 otherwise.
  - source_idx = cnt while source_valid; 0 otherwise.
- source_sop = source_valid & (cnt==0). source_eop = source_valid & (cnt==N-1).
- No arithmetic is performed: data passes bit-exact, with no scaling, rounding, or sign change.
- Data that the FFT pipeline scaled upstream must already be DATA_WIDTH wide.
- load_valid while load_ready=0: no capture. The buffer and FSM are unaffected, and upstream must hold the frame.
- source_ready=0 in STREAM: cnt, data, idx, sop and eop hold stable. source_valid stays 1 and never drops mid-frame.

## Timing
- Reset values: state=IDLE, cnt=0, buffer=0. Outputs: load_ready=1, source_valid=0, source_r=0, source_i=0, source_idx=0, sop=0, eop=0.
- Latency: a load transfer at edge k gives the first sample (sop) valid in the cycle after edge k.
- With source_ready held at 1, a frame occupies exactly N consecutive cycles.
- Back-to-back frames with a load on every N-th cycle sustain 100% output duty with no bubble.
- Reset asserted mid-frame aborts the stream immediately and asynchronously. All outputs go to their reset values, and the remaining samples are discarded.
- Load in IDLE and output transfer cannot coincide, because source_valid=0 in IDLE.

## Test plan
1. N=8, BIT_REV=0, sink_r[j]=j+1, sink_i[j]=-(j+1), single load, source_ready=1.
   -> 8 beats: r=1..8, i=-1..-8, idx=0..7; sop on beat 0, eop on beat 7; load_ready=0 on beats 0..6 and 1 on beat 7; IDLE afterwards.
2. Same frame, BIT_REV=1.
   -> source_r sequence 1,5,3,7,2,6,4,8; idx 0..7.
3. source_ready toggled 1,0,0,1,… during a frame.
   -> data, idx and flags stable on stall cycles; exactly 8 transfers with no duplicate or missing sample.
4. Second frame (values 101..108) held on load_valid from beat 3 of frame 1.
   -> captured only at the eop beat of frame 1; sample 101 follows sample 8 in the next cycle with no gap.
5. rst_n low for 1 cycle at beat 4 of a frame.
   -> all outputs 0 and load_ready=1 during reset; the next load streams a fresh frame from sop with correct data.
6. Full-scale values: sink_r[0]=-2^(DATA_WIDTH-1), sink_i[0]=2^(DATA_WIDTH-1)-1, with DATA_WIDTH=24.
   -> output bit-exact, sign preserved.
